usr_param: RTL and testbench

- Parametrised universal shift register. Successor to the fixed 4-bit SIPO stage.
- Supports hold, shift-right, shift-left and parallel load, all selected per cycle.
- A shift-frame counter flags each time WIDTH consecutive same-direction shifts complete a fresh serial word.
- Sits between serial link logic and parallel datapath; usable as SIPO, PISO, SISO or PIPO.

---
 rtl/usr_pkg.sv | 21 ++
 rtl/usr_param_if.sv | 33 +++
 rtl/usr_frame_ctr.sv | 60 ++++++
 rtl/usr_param.sv | 75 +++++++
 tb/tb_usr_param.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
package usr_pkg;

    typedef enum logic [1:0] {
        USR_HOLD = 2'b00,
        USR_SHR  = 2'b01,
        USR_SHL  = 2'b10,
        USR_LOAD = 2'b11
    } usr_mode_t;

    typedef enum logic {
        DIR_R = 1'b0,
        DIR_L = 1'b1
    } usr_dir_t;

    // Bit-counter width able to hold 0..width.
    function automatic int unsigned usr_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/usr_param_if.sv
// Control, data and status bundle of the universal shift register.
interface usr_param_if #(
    parameter int unsigned WIDTH = 4
);
    import usr_pkg::*;

    localparam int unsigned CNT_W = usr_cnt_w(WIDTH);

    logic             en;
    logic             clr;
    usr_mode_t        mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic [CNT_W-1:0] bit_cnt;
    logic             word_valid;

    // Driver side (link/datapath logic or bench).
    modport master (
        output en, clr, mode, sin_r, sin_l, pin,
        input  q, sout_r, sout_l, bit_cnt, word_valid
    );

    // Shift register side.
    modport slave (
        input  en, clr, mode, sin_r, sin_l, pin,
        output q, sout_r, sout_l, bit_cnt, word_valid
    );

endinterface

// File: rtl/usr_frame_ctr.sv
// Serial frame tracker: counts consecutive same-direction shifts and
// pulses word_valid when WIDTH of them have assembled a fresh word.
module usr_frame_ctr
    import usr_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = usr_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             shift_i,
    input  usr_dir_t         dir_i,
    input  logic             load_i,
    output logic [CNT_W-1:0] bit_cnt_o,
    output logic             word_valid_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    usr_dir_t         dir_q, dir_d;
    logic             wv_q, wv_d;

    // Next count/direction; the pulse defaults low so it lasts one cycle.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        wv_d  = 1'b0;
        if (clr_i || load_i) begin
            cnt_d = '0;
        end else if (shift_i) begin
            if (dir_i != dir_q) begin
                // Direction change restarts the frame; this shift is bit one.
                cnt_d = CNT_W'(1);
                dir_d = dir_i;
            end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
                cnt_d = '0;
                wv_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Frame state registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            dir_q <= DIR_R;
            wv_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            wv_q  <= wv_d;
        end
    end

    assign bit_cnt_o    = cnt_q;
    assign word_valid_o = wv_q;

endmodule

// File: rtl/usr_param.sv
// Parametrised universal shift register (hold / shift right / shift left /
// parallel load) with serial frame tracking.
module usr_param
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    usr_param_if.slave  bus
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             shift_c;
    logic             load_c;
    usr_dir_t         dir_c;

    // Data mux with clr > enable > mode priority; also derives frame strobes.
    always_comb begin
        q_d     = q_q;
        shift_c = 1'b0;
        load_c  = 1'b0;
        dir_c   = DIR_R;
        if (bus.clr) begin
            q_d = '0;
        end else if (bus.en) begin
            case (bus.mode)
                USR_SHR: begin
                    q_d     = {bus.sin_r, q_q[WIDTH-1:1]};
                    shift_c = 1'b1;
                    dir_c   = DIR_R;
                end
                USR_SHL: begin
                    q_d     = {q_q[WIDTH-2:0], bus.sin_l};
                    shift_c = 1'b1;
                    dir_c   = DIR_L;
                end
                USR_LOAD: begin
                    q_d    = bus.pin;
                    load_c = 1'b1;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    // Data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    usr_frame_ctr #(
        .WIDTH (WIDTH)
    ) u_frame_ctr (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (bus.clr),
        .shift_i      (shift_c),
        .dir_i        (dir_c),
        .load_i       (load_c),
        .bit_cnt_o    (bus.bit_cnt),
        .word_valid_o (bus.word_valid)
    );

    assign bus.q      = q_q;
    assign bus.sout_r = q_q[0];
    assign bus.sout_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_usr_param.sv
// Scoreboard bench for usr_param: directed scenarios plus random traffic,
// each cycle's expected state comes from a run-length reference model.
module tb_usr_param;
    import usr_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = $clog2(W + 1);

    typedef struct packed {
        logic [W-1:0]  q;
        logic [CW-1:0] cnt;
        logic          wv;
        logic          sr;
        logic          sl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    usr_param_if #(.WIDTH(W)) bus ();

    usr_param #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: register value, direction of the current run, and the
    // unbounded length of that run since the last frame boundary.
    logic [W-1:0] m_q   = '0;
    bit           m_dir = 1'b0;
    int           m_run = 0;
    logic         m_wv  = 1'b0;

    function automatic exp_t model_view();
        exp_t e;
        e.q   = m_q;
        e.cnt = CW'(m_run % W);
        e.wv  = m_wv;
        e.sr  = (m_q & W'(1)) != '0;
        e.sl  = (m_q >> (W - 1)) != '0;
        return e;
    endfunction

    task automatic check_now(input string name, input exp_t e);
        exp_t a;
        a.q   = bus.q;
        a.cnt = bus.bit_cnt;
        a.wv  = bus.word_valid;
        a.sr  = bus.sout_r;
        a.sl  = bus.sout_l;
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s @%0t: got q=%b cnt=%0d wv=%b sr=%b sl=%b, expected q=%b cnt=%0d wv=%b sr=%b sl=%b",
                     name, $time, a.q, a.cnt, a.wv, a.sr, a.sl, e.q, e.cnt, e.wv, e.sr, e.sl);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] q, input int cnt, input logic wv);
        exp_t e;
        e.q   = q;
        e.cnt = CW'(cnt);
        e.wv  = wv;
        e.sr  = q[0];
        e.sl  = q[W-1];
        return e;
    endfunction

    // Drive one cycle of inputs and push the state expected after the edge.
    task automatic step(input logic en, input logic clr, input logic [1:0] mode,
                        input logic sr, input logic sl, input logic [W-1:0] pin);
        bit d;
        @(negedge clk);
        bus.en    = en;
        bus.clr   = clr;
        bus.mode  = usr_mode_t'(mode);
        bus.sin_r = sr;
        bus.sin_l = sl;
        bus.pin   = pin;
        m_wv = 1'b0;
        if (clr) begin
            m_q   = '0;
            m_run = 0;
        end else if (en && mode == 2'd3) begin
            m_q   = pin;
            m_run = 0;
        end else if (en && mode != 2'd0) begin
            d = (mode == 2'd2);
            if (d) m_q = W'(m_q << 1) | W'(sl);
            else   m_q = (m_q >> 1) | (W'(sr) << (W - 1));
            if (d != m_dir) begin
                m_dir = d;
                m_run = 1;
            end else begin
                m_run = m_run + 1;
            end
            m_wv = (m_run % W) == 0;
        end
        exp_q.push_back(model_view());
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle with a pending expectation is compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_now("scoreboard", e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bit cur_l;
        int r;
        bus.en    = 1'b0;
        bus.clr   = 1'b0;
        bus.mode  = USR_HOLD;
        bus.sin_r = 1'b0;
        bus.sin_l = 1'b0;
        bus.pin   = '0;

        #3;
        check_now("reset_state", mk(4'b0000, 0, 1'b0));
        @(negedge clk);
        rst = 1'b1;

        // SIPO right: 1000, 0100, 1010, 0101 with pulse on the last.
        step(1, 0, 2'b01, 1, 0, '0);
        step(1, 0, 2'b01, 0, 0, '0);
        step(1, 0, 2'b01, 1, 0, '0);
        step(1, 0, 2'b01, 0, 0, '0);
        settle();
        check_now("sipo_word", mk(4'b0101, 0, 1'b1));

        // PISO left from 1011; sout_l walks 1,0,1,1.
        step(1, 0, 2'b11, 0, 0, 4'b1011);
        step(1, 0, 2'b10, 0, 0, '0);
        step(1, 0, 2'b10, 0, 0, '0);
        step(1, 0, 2'b10, 0, 0, '0);
        step(1, 0, 2'b10, 0, 0, '0);
        settle();
        check_now("piso_end", mk(4'b0000, 0, 1'b1));

        // Direction change restarts the count at one.
        step(1, 1, 2'b00, 0, 0, '0);
        step(1, 0, 2'b01, 1, 0, '0);
        step(1, 0, 2'b01, 1, 0, '0);
        step(1, 0, 2'b10, 0, 1, '0);
        settle();
        check_now("dir_change", mk(4'b1001, 1, 1'b0));
        step(1, 0, 2'b10, 0, 0, '0);
        step(1, 0, 2'b10, 0, 0, '0);
        step(1, 0, 2'b10, 0, 0, '0);
        settle();
        check_now("dir_frame", mk(4'b1000, 0, 1'b1));

        // Enable gap inside a frame keeps the partial count.
        step(1, 1, 2'b00, 0, 0, '0);
        step(1, 0, 2'b01, 1, 0, '0);
        step(1, 0, 2'b01, 1, 0, '0);
        step(0, 0, 2'b01, 1, 0, '0);
        step(0, 0, 2'b01, 1, 0, '0);
        step(0, 0, 2'b01, 1, 0, '0);
        settle();
        check_now("en_gap_hold", mk(4'b1100, 2, 1'b0));
        step(1, 0, 2'b01, 0, 0, '0);
        step(1, 0, 2'b01, 0, 0, '0);
        settle();
        check_now("en_gap_word", mk(4'b0011, 0, 1'b1));

        // Asynchronous reset between edges mid-frame.
        step(1, 1, 2'b00, 0, 0, '0);
        step(1, 0, 2'b01, 1, 0, '0);
        step(1, 0, 2'b01, 1, 0, '0);
        step(1, 0, 2'b01, 1, 0, '0);
        settle();
        check_now("pre_async", mk(4'b1110, 3, 1'b0));
        #1;
        rst    = 1'b0;
        bus.en = 1'b0;
        #1;
        check_now("async_reset", mk(4'b0000, 0, 1'b0));
        m_q   = '0;
        m_dir = 1'b0;
        m_run = 0;
        m_wv  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 2'b01, 1, 0, '0);
        step(1, 0, 2'b01, 1, 0, '0);
        step(1, 0, 2'b01, 1, 0, '0);
        step(1, 0, 2'b01, 1, 0, '0);
        settle();
        check_now("post_reset_word", mk(4'b1111, 0, 1'b1));

        // clr wins over en=0; load mid-frame cancels the frame.
        step(1, 0, 2'b11, 0, 0, 4'b1111);
        step(0, 1, 2'b11, 0, 0, 4'b1010);
        settle();
        check_now("clr_en_low", mk(4'b0000, 0, 1'b0));
        step(1, 0, 2'b01, 1, 0, '0);
        step(1, 0, 2'b01, 1, 0, '0);
        step(1, 0, 2'b01, 1, 0, '0);
        step(1, 0, 2'b11, 0, 0, 4'b0101);
        settle();
        check_now("load_mid_frame", mk(4'b0101, 0, 1'b0));

        // Random traffic with runs of one direction so frames complete.
        cur_l = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) cur_l = ~cur_l;
            r = int'($urandom_range(0, 9));
            step(1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 24) == 0),
                 (r == 0) ? 2'b00 : (r == 9) ? 2'b11 : (cur_l ? 2'b10 : 2'b01),
                 1'($urandom), 1'($urandom), W'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
